// File: rtl/dac_sample_bridge_pkg.sv
// Shared register map, CTRL bit positions and state encoding for the DAC sample bridge.
package dac_sample_bridge_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;

   localparam int CTRL_MUTE  = 0;
   localparam int CTRL_SWAP  = 1;
   localparam int CTRL_FLUSH = 2;

   localparam int STAT_RUNNING = 8;
   localparam int STAT_EMPTY   = 9;
   localparam int STAT_FULL    = 10;

   typedef enum logic {
      ST_PREFILL = 1'b0,
      ST_RUN     = 1'b1
   } state_t;

   // spdif_tx expects 24-bit audio words; the 16-bit sample sits in the MSBs.
   function automatic logic [23:0] dac_word(input logic [15:0] sample);
      return {sample, 8'h00};
   endfunction

endpackage

// File: rtl/dac_sample_bridge_sample_fifo.sv
// Synchronous stereo-frame FIFO with registered read data, updated only on a pop.
module sample_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int W          = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [W-1:0]          wdata,
   output logic [W-1:0]          rdata,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  empty,
   output logic                  full
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [W-1:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_reg;
   logic [DEPTH_LOG2-1:0]   rd_ptr_reg;
   logic [DEPTH_LOG2:0]     level_reg;
   logic [W-1:0]            rdata_reg;
   logic                    push_ok;
   logic                    pop_ok;

   assign empty = (level_reg == '0);
   // level never exceeds DEPTH, so its top bit alone marks a full FIFO
   assign full  = level_reg[DEPTH_LOG2];

   // A simultaneous pop frees the slot a full-FIFO push needs.
   assign pop_ok  = pop & ~empty & ~flush;
   assign push_ok = push & ~flush & (~full | pop_ok);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         rdata_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         rdata_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + (DEPTH_LOG2)'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + (DEPTH_LOG2)'(1);
            rdata_reg  <= mem[rd_ptr_reg];
         end
         case ({push_ok, pop_ok})
            2'b10:   level_reg <= level_reg + (DEPTH_LOG2 + 1)'(1);
            2'b01:   level_reg <= level_reg - (DEPTH_LOG2 + 1)'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

   assign rdata = rdata_reg;
   assign level = level_reg;

endmodule

// File: rtl/dac_sample_bridge.sv
// Elastic stereo buffer between the YM3016 decoder and spdif_tx, with a Wishbone control slot.
// Build option DAC_BRIDGE_STATS_EN adds saturating overflow/underrun counters at COUNT.
module dac_sample_bridge
   import dac_sample_bridge_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int PREFILL    = 8,
   parameter int DW         = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [15:0]     in_left,
   input  logic [15:0]     in_right,
   input  logic            out_sel,
   output logic [23:0]     out_data,
   input  logic [1:0]      wb_addr,
   input  logic [DW-1:0]   wb_wdata,
   output logic [DW-1:0]   wb_rdata,
   input  logic            wb_we,
   input  logic            wb_cyc,
   output logic            wb_ack
);

   localparam logic [DEPTH_LOG2:0] PREFILL_LVL = (DEPTH_LOG2 + 1)'(PREFILL);

   state_t                 state_reg;
   logic                   out_sel_d_reg;
   logic                   mute_reg;
   logic                   swap_reg;
   logic                   flush_reg;
   logic                   wb_ack_reg;
   logic [DW-1:0]          wb_rdata_reg;

   logic [31:0]            frame;
   logic [DEPTH_LOG2:0]    level;
   logic                   fifo_empty;
   logic                   fifo_full;

   logic                   advance;
   logic                   pop_req;
   logic                   pop_ok;
   logic                   underrun;
   logic                   overflow;
   logic                   wb_wr;
   logic                   wb_rd;
   logic                   ctrl_wr;
   logic [31:0]            status_word;
   logic [31:0]            count_word;
   logic [31:0]            rd_word;
   logic                   sel_eff;
   logic [15:0]            sample;
   logic                   unused_wdata;

   // spdif_tx starts a new frame when its channel select falls back to left.
   assign advance  = out_sel_d_reg & ~out_sel;
   assign pop_req  = (state_reg == ST_RUN) & advance;
   assign pop_ok   = pop_req & ~fifo_empty & ~flush_reg;
   assign underrun = pop_req & fifo_empty & ~flush_reg;
   assign overflow = in_valid & fifo_full & ~pop_ok & ~flush_reg;

   sample_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .W          (32)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (pop_req),
      .flush (flush_reg),
      .wdata ({in_left, in_right}),
      .rdata (frame),
      .level (level),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_PREFILL;
         out_sel_d_reg <= 1'b0;
      end else begin
         out_sel_d_reg <= out_sel;
         if (flush_reg) begin
            state_reg <= ST_PREFILL;
         end else begin
            case (state_reg)
               ST_PREFILL: if (level >= PREFILL_LVL) state_reg <= ST_RUN;
               ST_RUN:     if (underrun)             state_reg <= ST_PREFILL;
               default:    state_reg <= ST_PREFILL;
            endcase
         end
      end
   end

   assign wb_wr   = wb_cyc & wb_we & ~wb_ack_reg;
   assign wb_rd   = wb_cyc & ~wb_we & ~wb_ack_reg;
   assign ctrl_wr = wb_wr & (wb_addr == REG_CTRL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_ack_reg   <= 1'b0;
         wb_rdata_reg <= '0;
         mute_reg     <= 1'b0;
         swap_reg     <= 1'b0;
         flush_reg    <= 1'b0;
      end else begin
         wb_ack_reg   <= wb_cyc & ~wb_ack_reg;
         wb_rdata_reg <= wb_rd ? DW'(rd_word) : '0;
         flush_reg    <= ctrl_wr & wb_wdata[CTRL_FLUSH];
         if (ctrl_wr) begin
            mute_reg <= wb_wdata[CTRL_MUTE];
            swap_reg <= wb_wdata[CTRL_SWAP];
         end
      end
   end

   always_comb begin
      status_word                  = 32'h0;
      status_word[DEPTH_LOG2:0]    = level;
      status_word[STAT_RUNNING]    = (state_reg == ST_RUN);
      status_word[STAT_EMPTY]      = fifo_empty;
      status_word[STAT_FULL]       = fifo_full;
   end

   always_comb begin
      rd_word = 32'h0;
      case (wb_addr)
         REG_CTRL: begin
            rd_word[CTRL_MUTE] = mute_reg;
            rd_word[CTRL_SWAP] = swap_reg;
         end
         REG_STATUS: rd_word = status_word;
         REG_COUNT:  rd_word = count_word;
         default:    rd_word = 32'h0;
      endcase
   end

`ifdef DAC_BRIDGE_STATS_EN
   logic [1:0] cnt_evt;
   logic       cnt_clr;

   assign cnt_evt = {underrun, overflow};
   assign cnt_clr = wb_wr & (wb_addr == REG_COUNT);

   // Slice 0 counts overflows, slice 1 underruns; a COUNT write wins over a same-cycle event.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [15:0] cnt_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg <= '0;
            end else if (cnt_clr) begin
               cnt_reg <= '0;
            end else if (cnt_evt[gi] && (cnt_reg != 16'hFFFF)) begin
               cnt_reg <= cnt_reg + 16'd1;
            end
         end
         assign count_word[16*gi +: 16] = cnt_reg;
      end
   endgenerate
`else
   logic unused_stats;
   assign unused_stats = overflow;
   assign count_word   = 32'h0;
`endif

   assign unused_wdata = ^wb_wdata[DW-1:3];

   // Output mux stays combinational so spdif_tx sees the channel it selects without delay.
   assign sel_eff  = out_sel ^ swap_reg;
   assign sample   = sel_eff ? frame[15:0] : frame[31:16];
   assign out_data = mute_reg ? 24'h0 : dac_word(sample);

   assign wb_ack   = wb_ack_reg;
   assign wb_rdata = wb_rdata_reg;

endmodule

// File: tb/tb_dac_sample_bridge.sv
// Scoreboard bench for dac_sample_bridge: frames queue on push, dequeue on each modelled advance.
module tb_dac_sample_bridge;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;
   localparam logic [1:0] A_SPARE  = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_left = 16'h0;
   logic [15:0] in_right = 16'h0;
   logic        out_sel = 1'b0;
   logic [23:0] out_data;
   logic [1:0]  wb_addr = 2'd0;
   logic [31:0] wb_wdata = 32'h0;
   logic [31:0] wb_rdata;
   logic        wb_we = 1'b0;
   logic        wb_cyc = 1'b0;
   logic        wb_ack;

   int n_vec = 0;
   int n_err = 0;

   // reference model
   logic [31:0] sb_q[$];
   bit          m_run, m_mute, m_swap, m_flush_pend, sel_prev;
   logic [31:0] m_frame;
   int          m_ovf, m_unf;

   always #5 clk = ~clk;

   dac_sample_bridge #(
      .DEPTH_LOG2 (4),
      .PREFILL    (8),
      .DW         (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_left  (in_left),
      .in_right (in_right),
      .out_sel  (out_sel),
      .out_data (out_data),
      .wb_addr  (wb_addr),
      .wb_wdata (wb_wdata),
      .wb_rdata (wb_rdata),
      .wb_we    (wb_we),
      .wb_cyc   (wb_cyc),
      .wb_ack   (wb_ack)
   );

   function automatic logic [23:0] exp_out(input logic sel);
      logic [15:0] s;
      if (m_mute) return 24'h0;
      s = (sel ^ m_swap) ? m_frame[15:0] : m_frame[31:16];
      return {s, 8'h00};
   endfunction

   function automatic logic [31:0] exp_status();
      logic [31:0] v;
      v       = 32'h0;
      v[4:0]  = 5'(sb_q.size());
      v[8]    = m_run;
      v[9]    = (sb_q.size() == 0);
      v[10]   = (sb_q.size() == 16);
      return v;
   endfunction

   function automatic logic [31:0] exp_count();
`ifdef DAC_BRIDGE_STATS_EN
      return {16'(m_unf), 16'(m_ovf)};
`else
      return 32'h0;
`endif
   endfunction

   // Advance the model by one clock edge using the inputs currently driven, then clock the DUT.
   task automatic step();
      bit adv, pop_ok, unf, full, next_run;
      adv = sel_prev && !out_sel;
      if (m_flush_pend) begin
         sb_q.delete();
         m_run        = 1'b0;
         m_frame      = 32'h0;
         m_flush_pend = 1'b0;
      end else begin
         pop_ok   = m_run && adv && (sb_q.size() > 0);
         unf      = m_run && adv && (sb_q.size() == 0);
         full     = (sb_q.size() == 16);
         next_run = m_run ? !unf : (sb_q.size() >= 8);
         if (pop_ok) m_frame = sb_q.pop_front();
         if (in_valid) begin
            if (!full || pop_ok) sb_q.push_back({in_left, in_right});
            else if (m_ovf < 65535) m_ovf++;
         end
         if (unf && m_unf < 65535) m_unf++;
         m_run = next_run;
      end
      sel_prev = out_sel;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      out_sel  = 1'b0;
      wb_cyc   = 1'b0;
      wb_we    = 1'b0;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
      m_run = 0; m_mute = 0; m_swap = 0; m_flush_pend = 0; sel_prev = 0;
      m_frame = 32'h0; m_ovf = 0; m_unf = 0;
   endtask

   task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
      in_valid = 1'b1;
      in_left  = l;
      in_right = r;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_advance();
      out_sel = 1'b1;
      step();
      out_sel = 1'b0;
      step();
   endtask

   task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
      bit acked;
      acked   = 1'b0;
      d       = 'x;
      wb_addr = a;
      wb_we   = 1'b0;
      wb_cyc  = 1'b1;
      for (int k = 0; k < 4 && !acked; k++) begin
         step();
         if (wb_ack === 1'b1) begin
            acked = 1'b1;
            d     = wb_rdata;
         end
      end
      wb_cyc = 1'b0;
      step();
      $display("wb read  addr=%0d data=%h ack=%0d", a, d, acked);
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [31:0] dat, input bit push_in_ack);
      bit acked;
      acked    = 1'b0;
      wb_addr  = a;
      wb_wdata = dat;
      wb_we    = 1'b1;
      wb_cyc   = 1'b1;
      for (int k = 0; k < 4 && !acked; k++) begin
         step();
         if (wb_ack === 1'b1) acked = 1'b1;
      end
      if (acked) begin
         if (a == A_CTRL) begin
            m_mute       = dat[0];
            m_swap       = dat[1];
            m_flush_pend = dat[2];
         end
         if (a == A_COUNT) begin
            m_ovf = 0;
            m_unf = 0;
         end
      end
      wb_cyc = 1'b0;
      wb_we  = 1'b0;
      if (push_in_ack) begin
         in_valid = 1'b1;
         in_left  = 16'hDEAD;
         in_right = 16'hBEEF;
      end
      step();
      in_valid = 1'b0;
      $display("wb write addr=%0d data=%h ack=%0d", a, dat, acked);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      n_vec++;
      if (out_data !== 24'h0) begin
         n_err++; $display("FAIL reset_out_data: got %h expected %h", out_data, 24'h0);
      end
      n_vec++;
      if (wb_ack !== 1'b0 || wb_rdata !== 32'h0) begin
         n_err++; $display("FAIL reset_wb: got ack=%b rdata=%h expected ack=0 rdata=0", wb_ack, wb_rdata);
      end
      for (int i = 0; i < 6; i++) begin
         out_sel = ~out_sel;
         step();
         step();
         n_vec++;
         if (out_data !== exp_out(out_sel)) begin
            n_err++; $display("FAIL idle_out_%0d: got %h expected %h", i, out_data, exp_out(out_sel));
         end
      end
      wb_read(A_STATUS, d);
      n_vec++;
      if (d !== 32'h200) begin
         n_err++; $display("FAIL reset_status: got %h expected %h", d, 32'h200);
      end
      wb_read(A_CTRL, d);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h0);
      end
      wb_read(A_COUNT, d);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++; $display("FAIL reset_count: got %h expected %h", d, 32'h0);
      end
      wb_read(A_SPARE, d);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++; $display("FAIL spare_read: got %h expected %h", d, 32'h0);
      end
   endtask

   task automatic test_prefill_run();
      logic [31:0] d, e;
      do_reset();
      out_sel = 1'b1;
      for (int i = 0; i < 8; i++) push_frame(16'h1234, 16'hABCD);
      step();
      e = exp_status();
      wb_read(A_STATUS, d);
      n_vec++;
      if (d !== e) begin
         n_err++; $display("FAIL prefill_done_status: got %h expected %h", d, e);
      end
      out_sel = 1'b0;
      step();
      n_vec++;
      if (out_data !== exp_out(1'b0) || out_data !== 24'h123400) begin
         n_err++; $display("FAIL run_left: got %h expected %h", out_data, exp_out(1'b0));
      end
      out_sel = 1'b1;
      #1;
      n_vec++;
      if (out_data !== exp_out(1'b1) || out_data !== 24'hABCD00) begin
         n_err++; $display("FAIL run_right: got %h expected %h", out_data, exp_out(1'b1));
      end
      e = exp_status();
      wb_read(A_STATUS, d);
      n_vec++;
      if (d !== e || d !== 32'h107) begin
         n_err++; $display("FAIL run_status: got %h expected %h", d, e);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d, e;
      do_reset();
      for (int i = 0; i < 20; i++) push_frame(16'(i), 16'(~i));
      e = exp_status();
      wb_read(A_STATUS, d);
      n_vec++;
      if (d !== e || d !== 32'h510) begin
         n_err++; $display("FAIL ovf_status: got %h expected %h", d, e);
      end
      e = exp_count();
      wb_read(A_COUNT, d);
      n_vec++;
      if (d !== e) begin
         n_err++; $display("FAIL ovf_count: got %h expected %h", d, e);
      end
      wb_write(A_COUNT, 32'hFFFF_FFFF, 1'b0);
      e = exp_count();
      wb_read(A_COUNT, d);
      n_vec++;
      if (d !== e) begin
         n_err++; $display("FAIL count_clear: got %h expected %h", d, e);
      end
   endtask

   task automatic test_underrun();
      logic [31:0] d, e;
      do_reset();
      out_sel = 1'b1;
      for (int i = 0; i < 8; i++) push_frame(16'h0100 + 16'(i), 16'h0200 + 16'(i));
      step();
      repeat (7) do_advance();
      e = exp_status();
      wb_read(A_STATUS, d);
      n_vec++;
      if (d !== e) begin
         n_err++; $display("FAIL one_left_status: got %h expected %h", d, e);
      end
      do_advance();
      n_vec++;
      if (out_data !== exp_out(1'b0)) begin
         n_err++; $display("FAIL last_frame: got %h expected %h", out_data, exp_out(1'b0));
      end
      do_advance();
      n_vec++;
      if (out_data !== exp_out(1'b0)) begin
         n_err++; $display("FAIL underrun_hold: got %h expected %h", out_data, exp_out(1'b0));
      end
      e = exp_status();
      wb_read(A_STATUS, d);
      n_vec++;
      if (d !== e) begin
         n_err++; $display("FAIL underrun_status: got %h expected %h", d, e);
      end
      e = exp_count();
      wb_read(A_COUNT, d);
      n_vec++;
      if (d !== e) begin
         n_err++; $display("FAIL underrun_count: got %h expected %h", d, e);
      end
      for (int i = 0; i < 7; i++) begin
         out_sel = 1'b1;
         push_frame(16'h0300 + 16'(i), 16'h0400 + 16'(i));
         out_sel = 1'b0;
         step();
      end
      e = exp_status();
      wb_read(A_STATUS, d);
      n_vec++;
      if (d !== e) begin
         n_err++; $display("FAIL refill_status: got %h expected %h", d, e);
      end
      n_vec++;
      if (out_data !== exp_out(1'b0)) begin
         n_err++; $display("FAIL refill_hold: got %h expected %h", out_data, exp_out(1'b0));
      end
      out_sel = 1'b1;
      push_frame(16'h0307, 16'h0407);
      step();
      out_sel = 1'b0;
      step();
      n_vec++;
      if (out_data !== exp_out(1'b0)) begin
         n_err++; $display("FAIL refill_pop: got %h expected %h", out_data, exp_out(1'b0));
      end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] d, e;
      do_reset();
      out_sel = 1'b1;
      for (int i = 0; i < 16; i++) push_frame(16'h4000 + 16'(i), 16'h5000 + 16'(i));
      out_sel  = 1'b0;
      in_valid = 1'b1;
      in_left  = 16'h4AAA;
      in_right = 16'h5BBB;
      step();
      in_valid = 1'b0;
      n_vec++;
      if (out_data !== exp_out(1'b0)) begin
         n_err++; $display("FAIL full_pop_frame: got %h expected %h", out_data, exp_out(1'b0));
      end
      e = exp_status();
      wb_read(A_STATUS, d);
      n_vec++;
      if (d !== e || d !== 32'h510) begin
         n_err++; $display("FAIL full_pushpop_status: got %h expected %h", d, e);
      end
      e = exp_count();
      wb_read(A_COUNT, d);
      n_vec++;
      if (d !== e) begin
         n_err++; $display("FAIL full_pushpop_count: got %h expected %h", d, e);
      end
   endtask

   task automatic test_ctrl();
      logic [31:0] d, e;
      do_reset();
      out_sel = 1'b1;
      for (int i = 0; i < 8; i++) push_frame(16'h1357, 16'h2468);
      step();
      out_sel = 1'b0;
      step();
      wb_write(A_CTRL, 32'h3, 1'b0);
      out_sel = 1'b0;
      #1;
      n_vec++;
      if (out_data !== exp_out(1'b0)) begin
         n_err++; $display("FAIL mute_left: got %h expected %h", out_data, exp_out(1'b0));
      end
      out_sel = 1'b1;
      #1;
      n_vec++;
      if (out_data !== exp_out(1'b1)) begin
         n_err++; $display("FAIL mute_right: got %h expected %h", out_data, exp_out(1'b1));
      end
      wb_read(A_CTRL, d);
      n_vec++;
      if (d !== 32'h3) begin
         n_err++; $display("FAIL ctrl_read: got %h expected %h", d, 32'h3);
      end
      wb_write(A_CTRL, 32'h2, 1'b0);
      out_sel = 1'b0;
      #1;
      n_vec++;
      if (out_data !== exp_out(1'b0) || out_data !== 24'h246800) begin
         n_err++; $display("FAIL swap_sel0: got %h expected %h", out_data, exp_out(1'b0));
      end
      out_sel = 1'b1;
      #1;
      n_vec++;
      if (out_data !== exp_out(1'b1)) begin
         n_err++; $display("FAIL swap_sel1: got %h expected %h", out_data, exp_out(1'b1));
      end
      wb_write(A_CTRL, 32'h4, 1'b1);
      wb_read(A_CTRL, d);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++; $display("FAIL flush_ctrl_read: got %h expected %h", d, 32'h0);
      end
      e = exp_status();
      wb_read(A_STATUS, d);
      n_vec++;
      if (d !== e || d !== 32'h200) begin
         n_err++; $display("FAIL flush_status: got %h expected %h", d, e);
      end
      n_vec++;
      if (out_data !== 24'h0) begin
         n_err++; $display("FAIL flush_out: got %h expected %h", out_data, 24'h0);
      end
      out_sel = 1'b1;
      for (int i = 0; i < 8; i++) push_frame(16'h7700 + 16'(i), 16'h6600 + 16'(i));
      step();
      out_sel = 1'b0;
      step();
      n_vec++;
      if (out_data !== exp_out(1'b0)) begin
         n_err++; $display("FAIL prereset_out: got %h expected %h", out_data, exp_out(1'b0));
      end
      wb_addr = A_STATUS;
      wb_we   = 1'b0;
      wb_cyc  = 1'b1;
      step();
      n_vec++;
      if (wb_ack !== 1'b1) begin
         n_err++; $display("FAIL prereset_ack: got %b expected %b", wb_ack, 1'b1);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if (out_data !== 24'h0 || wb_ack !== 1'b0 || wb_rdata !== 32'h0) begin
         n_err++; $display("FAIL async_reset: got out=%h ack=%b rdata=%h expected all 0", out_data, wb_ack, wb_rdata);
      end
      wb_cyc = 1'b0;
      do_reset();
      e = exp_status();
      wb_read(A_STATUS, d);
      n_vec++;
      if (d !== e) begin
         n_err++; $display("FAIL postreset_status: got %h expected %h", d, e);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_prefill_run();
      test_overflow();
      test_underrun();
      test_full_push_pop();
      test_ctrl();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
